// File: rtl/multi_edge_debounce.sv
// Multi-channel input conditioner: synchroniser, stable-count debounce filter,
// selectable edge pulse and sticky write-1-to-clear event flag per channel.

module multi_edge_debounce_ch #(
   parameter int SYNC_STAGES = 3,
   parameter int DB_CYCLES   = 4,
   parameter bit RST_LEVEL   = 1'b0,
   parameter int CNT_W       = 3
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       sig,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       clr,
   output logic       level,
   output logic       pulse,
   output logic       evt
);
   typedef enum logic {STABLE, PENDING} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   level_nxt, pulse_nxt, evt_nxt, commit, s;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync  <= {SYNC_STAGES{RST_LEVEL}};
         state <= STABLE;
         cnt   <= '0;
         level <= RST_LEVEL;
         pulse <= 1'b0;
         evt   <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], sig};
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         pulse <= pulse_nxt;
         evt   <= evt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      pulse_nxt = 1'b0;
      commit    = 1'b0;
      // a pulse in the same cycle as a clear keeps the flag set
      evt_nxt   = pulse | (evt & ~clr);
      if (!en) begin
         // track silently so re-enabling never reports a stale edge
         state_nxt = STABLE;
         cnt_nxt   = '0;
         level_nxt = s;
      end else begin
         case (state)
            STABLE:
               if (s != level) begin
                  if (DB_CYCLES == 1) commit = 1'b1;
                  else begin
                     cnt_nxt   = CNT_W'(1);
                     state_nxt = PENDING;
                  end
               end
            PENDING:
               if (s == level) begin
                  cnt_nxt   = '0;
                  state_nxt = STABLE;
               end else if (cnt == CNT_W'(DB_CYCLES-1)) commit = 1'b1;
               else cnt_nxt = cnt + CNT_W'(1);
            default: state_nxt = STABLE;
         endcase
         if (commit) begin
            level_nxt = s;
            cnt_nxt   = '0;
            state_nxt = STABLE;
            pulse_nxt = (mode[0] & s) | (mode[1] & ~s);
         end
      end
   end
endmodule

module multi_edge_debounce #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 3,
   parameter int DB_CYCLES   = 4,
   parameter bit RST_LEVEL   = 1'b0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [CH-1:0]   sig_i,
   input  logic            en_i,
   input  logic [2*CH-1:0] mode_i,
   input  logic [CH-1:0]   clr_i,
   output logic [CH-1:0]   level_o,
   output logic [CH-1:0]   pulse_o,
   output logic [CH-1:0]   evt_o,
   output logic            any_pulse_o
);
   localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES+1);

   for (genvar c = 0; c < CH; c++) begin : g_ch
      multi_edge_debounce_ch #(
         .SYNC_STAGES(SYNC_STAGES),
         .DB_CYCLES  (DB_CYCLES),
         .RST_LEVEL  (RST_LEVEL),
         .CNT_W      (CNT_W)
      ) u_ch (
         .clk  (clk),
         .rstn (rstn),
         .sig  (sig_i[c]),
         .en   (en_i),
         .mode (mode_i[2*c+1:2*c]),
         .clr  (clr_i[c]),
         .level(level_o[c]),
         .pulse(pulse_o[c]),
         .evt  (evt_o[c])
      );
   end

   assign any_pulse_o = |pulse_o;
endmodule

// File: doc/multi_edge_debounce.md
# multi_edge_debounce

Parametrised multi-channel input conditioner for the vending-machine front end (coin-slot sensors, selection and cancel buttons). Each channel synchronises an asynchronous input, filters bounce with a consecutive-stable-cycle counter, and emits a one-cycle pulse on a per-channel selectable edge: rising, falling, or both. Per-channel sticky event flags with write-1-to-clear let the FSM consume events at its own pace. With DB_CYCLES=1, SYNC_STAGES=2 and rising mode, each channel has the latency of the current single-channel rising-edge detector.

## Interface
- CH, 4: number of independent channels (≥1).
- SYNC_STAGES, 3: synchroniser flop depth (≥2).
- DB_CYCLES, 4: consecutive cycles the synchronised value must differ from the filtered level before the level is accepted (≥1).
- RST_LEVEL, 0: reset value of synchroniser flops and filtered level, all channels.
- CNT_W, $clog2(DB_CYCLES+1): debounce counter width (derived; do not override).
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- sig_i  in  CH  raw asynchronous inputs.
- en_i  in  1  global enable.
- mode_i  in  2*CH  per-channel edge select, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
- clr_i  in  CH  write-1-to-clear for evt_o, single-cycle strobes.
- level_o  out  CH  debounced level, registered.
- pulse_o  out  CH  one-cycle qualified edge pulse, registered.
- evt_o  out  CH  sticky event flags.
- any_pulse_o  out  1  OR of pulse_o.

## Operation
- Reset:
  - Every synchroniser flop and level_o = RST_LEVEL.
  - Counters = 0; pulse_o = 0; evt_o = 0; any_pulse_o = 0.
- Per channel c, let s = last synchroniser stage. The channel has two states: STABLE (cnt = 0) and PENDING (cnt > 0).
- en_i=1, s == level:
  - cnt <= 0; the channel returns to STABLE.
  - A bounce back to the old level aborts the pending change with no pulse.
- en_i=1, s != level, cnt < DB_CYCLES-1:
  - cnt <= cnt+1; the channel enters or stays in PENDING.
- en_i=1, s != level, cnt == DB_CYCLES-1 (commit):
  - level <= s; cnt <= 0.
  - pulse <= qualified edge: rise if mode has bit0 and s=1; fall if mode has bit1 and s=0.
- en_i=0:
  - level <= s; cnt <= 0; pulse <= 0.
  - The synchroniser keeps running.
  - Re-enabling never produces a pulse for a level that already changed while disabled.
- mode_i is sampled only at commit.
  - A mode change mid-PENDING affects only whether that commit pulses.
  - level_o updates regardless of mode, including mode 00.
- evt_o[c]:
  - Set when pulse_o[c] is asserted, i.e. on the cycle after the commit edge.
  - Cleared by clr_i[c]=1. When set and clear occur in the same cycle, set wins.
- Channels are fully independent. Simultaneous commits on several channels all pulse in the same cycle.
- Counter never exceeds DB_CYCLES-1; no wrap.

## Timing
- Take sig_i changing and stable before edge 1.
- Edge SYNC_STAGES: s carries the new value.
- Edges SYNC_STAGES+1 … SYNC_STAGES+DB_CYCLES: mismatch is counted.
- After edge SYNC_STAGES+DB_CYCLES: level_o and pulse_o update. Defaults give edge 7.
- pulse_o is high for exactly one cycle per commit.
  - Minimum spacing between pulses on one channel is DB_CYCLES cycles.
  - With DB_CYCLES=1, a sustained toggling s alternates commits every cycle.
- evt_o rises one cycle after pulse_o. any_pulse_o is combinational from the pulse_o registers, so it has zero added latency.
- Reset mid-PENDING: counter and state are lost immediately. The pending edge pulses only if the input is still changed after release, counted afresh from reset values.

## Test plan
- Defaults, mode 01 on ch0, sig_i[0] 0→1 held high:
  - level_o[0]=1 and pulse_o[0]=1 for one cycle after edge 7.
  - evt_o[0]=1 after edge 8.
  - No other channel changes.
- Bounce, ch1 mode 11, sig_i[1] pattern 1,1,0,1,1,1,1 (one value per cycle):
  - The glitch restarts the count, so the single pulse arrives 4 cycles after the last re-qualification start, not earlier.
  - Exactly one pulse is produced.
- Fall-only, ch2 mode 10, input 0→1→0 with each level held 10 cycles:
  - No pulse on the rise; level_o[2] still follows.
  - One pulse on the fall.
- en_i=0 while sig_i[3] rises, then en_i=1:
  - level_o[3] follows s.
  - pulse_o[3] stays 0 throughout, including after re-enable.
- All four channels rise in the same cycle, ch3 with clr_i[3] asserted on the cycle evt_o[3] sets:
  - Four simultaneous pulses; any_pulse_o=1 for one cycle.
  - evt_o[3] stays 1 (set wins), and clears on the next clr_i[3].
- DB_CYCLES=1, SYNC_STAGES=2, mode 01:
  - pulse_o high after edge 3.
  - Assert rstn=0 mid-PENDING with DB_CYCLES=4: all outputs return to reset values immediately.
